// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Each op is accepted in IDLE, executes for one cycle and responds for one cycle.
module alu_arbiter #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 5,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_c,
  output logic              rsp_z,
  output logic              rsp_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_s
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_grant_q, last_grant_d, grant, accept;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_result_q, rsp_result_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic rsp_c_q, rsp_c_d, rsp_z_q, rsp_z_d, rsp_s_q, rsp_s_d;
  logic capture;
  always_comb begin
    // on a tie, round-robin favours whoever did not win last time
    grant = (req0_valid && req1_valid) ? ((PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q) : req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant;
    req1_ready = (state_q == IDLE) && req1_valid && grant;
    accept = req0_ready || req1_ready;
    capture = (state_q == EXEC);
    owner_d = accept ? grant : owner_q;
    last_grant_d = accept ? grant : last_grant_q;
    alu_a_d = accept ? (grant ? req1_a : req0_a) : alu_a_q;
    alu_b_d = accept ? (grant ? req1_b : req0_b) : alu_b_q;
    alu_op_d = accept ? (grant ? req1_op : req0_op) : alu_op_q;
    rsp_result_d = capture ? alu_result : rsp_result_q;
    rsp_c_d = capture ? alu_c : rsp_c_q;
    rsp_z_d = capture ? alu_z : rsp_z_q;
    rsp_s_d = capture ? alu_s : rsp_s_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      default: state_d = IDLE;
    endcase
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) && owner_q;
    alu_a = alu_a_q;
    alu_b = alu_b_q;
    alu_op = alu_op_q;
    rsp_result = rsp_result_q;
    rsp_c = rsp_c_q;
    rsp_z = rsp_z_q;
    rsp_s = rsp_s_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      rsp_result_q <= '0;
      rsp_c_q <= 1'b0;
      rsp_z_q <= 1'b0;
      rsp_s_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_grant_q <= last_grant_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_op_q <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_c_q <= rsp_c_d;
      rsp_z_q <= rsp_z_d;
      rsp_s_q <= rsp_s_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: round-robin (p_*) and fixed-priority (f_*) instances share one set of requesters,
// each driving its own behavioural ALU; responses are checked against a queue of expected results.
module tb_alu_arbiter;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_CMP = 5'd2;
  typedef struct packed {logic [1:0] v; logic [7:0] r; logic c, z, s;} rsp_t;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0] req0_op = '0, req1_op = '0;
  logic p_r0_rdy, p_r1_rdy, p_rsp0, p_rsp1, p_c, p_z, p_s, p_alu_c, p_alu_z, p_alu_s;
  logic [7:0] p_res, p_alu_a, p_alu_b, p_alu_r;
  logic [4:0] p_alu_op;
  logic f_r0_rdy, f_r1_rdy, f_rsp0, f_rsp1, f_c, f_z, f_s, f_alu_c, f_alu_z, f_alu_s;
  logic [7:0] f_res, f_alu_a, f_alu_b, f_alu_r;
  logic [4:0] f_alu_op;
  int checks = 0, failures = 0;
  rsp_t sb[$];
  always #5 clk = ~clk;
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    logic [8:0] d;
    logic [7:0] r;
    logic c, z, s;
    d = (op == OP_ADD) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, a} - {1'b0, b});
    r = (op == OP_ADD || op == OP_SUB) ? d[7:0] : a;
    c = (op <= OP_CMP) ? d[8] : 1'b0;
    z = (op <= OP_CMP) ? (d[7:0] == 8'h00) : 1'b0;
    s = (op <= OP_CMP) ? d[7] : 1'b0;
    return {c, z, s, r};
  endfunction
  assign {p_alu_c, p_alu_z, p_alu_s, p_alu_r} = alu_f(p_alu_a, p_alu_b, p_alu_op);
  assign {f_alu_c, f_alu_z, f_alu_s, f_alu_r} = alu_f(f_alu_a, f_alu_b, f_alu_op);
  alu_arbiter #(.DATA_W(8), .OP_W(5), .PRIO_FIXED(0)) u_p (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(p_r0_rdy),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(p_r1_rdy),
    .rsp0_valid(p_rsp0), .rsp1_valid(p_rsp1), .rsp_result(p_res), .rsp_c(p_c), .rsp_z(p_z), .rsp_s(p_s),
    .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_op(p_alu_op),
    .alu_result(p_alu_r), .alu_c(p_alu_c), .alu_z(p_alu_z), .alu_s(p_alu_s));
  alu_arbiter #(.DATA_W(8), .OP_W(5), .PRIO_FIXED(1)) u_f (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(f_r0_rdy),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(f_r1_rdy),
    .rsp0_valid(f_rsp0), .rsp1_valid(f_rsp1), .rsp_result(f_res), .rsp_c(f_c), .rsp_z(f_z), .rsp_s(f_s),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op),
    .alu_result(f_alu_r), .alu_c(f_alu_c), .alu_z(f_alu_z), .alu_s(f_alu_s));
  task automatic wait_rsp(input int lim, output logic ok, output rsp_t got);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (p_rsp0 || p_rsp1) begin
        ok = 1'b1;
        got = {p_rsp1, p_rsp0, p_res, p_c, p_z, p_s};
      end
    end
  endtask
  task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask
  task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    rsp_t got, exp;
    logic ok;
    pulse_reset();
    drive0(1'b1, 8'h01, 8'h02, OP_ADD);
    @(posedge clk);
    #2;
    drive0(1'b0, 8'h01, 8'h02, OP_ADD);
    reset = 1'b1;
    #1;
    checks++;
    if ({p_r0_rdy, p_r1_rdy, p_rsp0, p_rsp1, p_res, p_c, p_z, p_s, p_alu_a, p_alu_b, p_alu_op} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got a=%h b=%h op=%h res=%h rdy=%b%b rsp=%b%b required all zero",
               p_alu_a, p_alu_b, p_alu_op, p_res, p_r0_rdy, p_r1_rdy, p_rsp0, p_rsp1);
    end
    @(negedge clk);
    reset = 1'b0;
    drive0(1'b1, 8'h10, 8'h20, OP_ADD);
    drive1(1'b1, 8'h05, 8'h06, OP_SUB);
    #1;
    checks++;
    if ({p_r0_rdy, p_r1_rdy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_first_tie ready=%b%b required=10", p_r0_rdy, p_r1_rdy);
    end
    sb.push_back({2'b01, 8'h30, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    drive1(1'b0, 8'h00, 8'h00, OP_ADD);
    wait_rsp(1, ok, got);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL reset_first_rsp ok=%0d got=%h required=%h", ok, got, exp);
    end
  endtask
  task automatic test_add_overflow();
    rsp_t got, exp;
    logic ok;
    @(negedge clk);
    drive0(1'b1, 8'h80, 8'h80, OP_ADD);
    sb.push_back({2'b01, 8'h00, 1'b1, 1'b1, 1'b0});
    #1;
    checks++;
    if (p_r0_rdy !== 1'b1) begin
      failures++;
      $display("FAIL add_ready got=%b required=1", p_r0_rdy);
    end
    @(negedge clk);
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    wait_rsp(1, ok, got);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL add_rsp ok=%0d got=%h required=%h", ok, got, exp);
    end
    @(negedge clk);
    checks++;
    if ({p_rsp0, p_rsp1} !== 2'b00) begin
      failures++;
      $display("FAIL add_single_pulse rsp=%b%b required=00", p_rsp1, p_rsp0);
    end
  endtask
  task automatic test_round_robin();
    rsp_t got, exp;
    logic ok;
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      sb.push_back({2'b01, 8'h02, 1'b0, 1'b0, 1'b0});
      sb.push_back({2'b10, 8'hFF, 1'b1, 1'b0, 1'b1});
    end
    drive0(1'b1, 8'h01, 8'h01, OP_ADD);
    drive1(1'b1, 8'h05, 8'h06, OP_SUB);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(4, ok, got);
      exp = sb.pop_front();
      checks++;
      if (!ok || got !== exp) begin
        failures++;
        $display("FAIL rr_rsp%0d ok=%0d got=%h required=%h", k, ok, got, exp);
      end
    end
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    drive1(1'b0, 8'h00, 8'h00, OP_ADD);
  endtask
  task automatic test_fixed_prio();
    int n0;
    n0 = 0;
    pulse_reset();
    drive0(1'b1, 8'h01, 8'h01, OP_ADD);
    drive1(1'b1, 8'h05, 8'h06, OP_SUB);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (f_r1_rdy !== 1'b0 || f_rsp1 !== 1'b0) begin
        failures++;
        $display("FAIL fixed_no_req1 cycle=%0d ready1=%b rsp1=%b required 0", i, f_r1_rdy, f_rsp1);
      end
      if (f_rsp0) begin
        n0++;
        checks++;
        if ({f_res, f_c, f_z, f_s} !== {8'h02, 3'b000}) begin
          failures++;
          $display("FAIL fixed_rsp_value got=%h c=%b z=%b s=%b required=02 000", f_res, f_c, f_z, f_s);
        end
      end
    end
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    drive1(1'b0, 8'h00, 8'h00, OP_ADD);
    checks++;
    if (n0 != 4) begin
      failures++;
      $display("FAIL fixed_rsp_count got=%0d required=4", n0);
    end
  endtask
  task automatic test_cmp_busy();
    rsp_t got, exp;
    logic ok;
    @(negedge clk);
    drive1(1'b1, 8'h33, 8'h33, OP_CMP);
    sb.push_back({2'b10, 8'h33, 1'b0, 1'b1, 1'b0});
    #1;
    checks++;
    if (p_r1_rdy !== 1'b1) begin
      failures++;
      $display("FAIL cmp_ready got=%b required=1", p_r1_rdy);
    end
    @(negedge clk);
    checks++;
    if (p_r1_rdy !== 1'b0) begin
      failures++;
      $display("FAIL cmp_busy_exec ready1=%b required=0", p_r1_rdy);
    end
    wait_rsp(1, ok, got);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp || p_r1_rdy !== 1'b0) begin
      failures++;
      $display("FAIL cmp_rsp ok=%0d got=%h ready1=%b required=%h ready1=0", ok, got, p_r1_rdy, exp);
    end
    drive1(1'b0, 8'h00, 8'h00, OP_ADD);
    @(negedge clk);
    checks++;
    if ({p_alu_a, p_alu_b, p_alu_op, p_res, p_rsp1} !== {8'h33, 8'h33, OP_CMP, 8'h33, 1'b0}) begin
      failures++;
      $display("FAIL cmp_hold a=%h b=%h op=%h res=%h rsp1=%b required 33 33 02 33 0",
               p_alu_a, p_alu_b, p_alu_op, p_res, p_rsp1);
    end
  endtask
  task automatic test_reset_in_exec();
    rsp_t got, exp;
    logic ok;
    int seen;
    seen = 0;
    @(negedge clk);
    drive0(1'b1, 8'h05, 8'h06, OP_ADD);
    @(negedge clk);
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (p_rsp0 || p_rsp1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL exec_reset_no_rsp pulses=%0d required=0", seen);
    end
    drive0(1'b1, 8'h7F, 8'h01, OP_ADD);
    drive1(1'b1, 8'h09, 8'h01, OP_SUB);
    #1;
    checks++;
    if ({p_r0_rdy, p_r1_rdy} !== 2'b10) begin
      failures++;
      $display("FAIL exec_reset_tie ready=%b%b required=10", p_r0_rdy, p_r1_rdy);
    end
    sb.push_back({2'b01, 8'h80, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    drive0(1'b0, 8'h00, 8'h00, OP_ADD);
    drive1(1'b0, 8'h00, 8'h00, OP_ADD);
    wait_rsp(1, ok, got);
    exp = sb.pop_front();
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("FAIL exec_reset_rsp ok=%0d got=%h required=%h", ok, got, exp);
    end
  endtask
  initial begin
    test_reset();
    test_add_overflow();
    test_round_robin();
    test_fixed_prio();
    test_cmp_busy();
    test_reset_in_exec();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
